bitrev_reorder: RTL and testbench

Output reorder buffer for the R2SDF FFT pipeline. Accepts the FFT's output stream, which arrives in bit-reversed index order, and re-emits each 2^N-sample frame in natural order 0..2^N-1. Two ping-pong banks allow one frame to be written while the previous frame is drained, giving sustained one-sample-per-cycle throughput. The write address is the bit-reverse of the arrival count, the same mapping used by the input-side shuffle.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/reorder_bank.sv | 22 ++
 rtl/bitrev_reorder.sv | 92 +++++++++
 tb/tb_bitrev_reorder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default order, complex sample type and the
// bit-reversal used by both the input shuffle and the output reorder.
package fft_pkg;

  localparam int FFT_N = 3;
  localparam int FFT_W = 16;

  // Reader state per bank: the bank FULL flag doubles as the state bit.
  localparam logic [0:0] RD_IDLE  = 1'b0;
  localparam logic [0:0] RD_DRAIN = 1'b1;

  typedef struct packed {
    logic signed [FFT_W-1:0] re;
    logic signed [FFT_W-1:0] im;
  } cplx_t;

  // Reverses the low n bits of k; bits at and above n are returned as 0.
  function automatic logic [15:0] rev_bit(input logic [15:0] k, input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < n) r[i] = k[n-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_bank.sv
// One reorder frame store: synchronous write, asynchronous read, no reset.
module reorder_bank #(
  parameter int N  = 3,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [N-1:0]  waddr,
  input  logic [DW-1:0] wdata,
  input  logic [N-1:0]  raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bitrev_reorder.sv
// Ping-pong output reorder for the R2SDF FFT: frames arrive in bit-reversed
// order, get written at rev(arrival count), and are drained in natural order.
import fft_pkg::*;

module bitrev_reorder #(
  parameter int N = FFT_N,
  parameter int W = FFT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_re,
  output logic signed [W-1:0] out_im,
  output logic [N-1:0]        out_idx,
  output logic                out_last
);

  logic [1:0]     full;
  logic           wr_sel;
  logic           rd_sel;
  logic [N-1:0]   wr_cnt;
  logic [N-1:0]   rd_cnt;
  logic [N-1:0]   wr_addr;
  logic           wr_fire;
  logic           rd_fire;
  logic [0:0]     rd_state;
  logic [2*W-1:0] wdata;
  logic [2*W-1:0] rdata [2];
  logic [2*W-1:0] rd_data;

  assign in_ready = !full[wr_sel];
  assign wr_fire  = in_valid & in_ready;
  assign wr_addr  = N'(rev_bit(16'(wr_cnt), N));
  assign wdata    = {in_re, in_im};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    reorder_bank #(
      .N  (N),
      .DW (2*W)
    ) u_bank (
      .clk   (clk),
      .we    (wr_fire && (wr_sel == 1'(b))),
      .waddr (wr_addr),
      .wdata (wdata),
      .raddr (rd_cnt),
      .rdata (rdata[b])
    );
  end

  // Read side: combinational storage read, indexed by the registered pointer.
  assign rd_state  = full[rd_sel];
  assign out_valid = (rd_state == RD_DRAIN);
  assign rd_fire   = out_valid & out_ready;
  assign rd_data   = rdata[rd_sel];

  assign out_re   = out_valid ? rd_data[2*W-1:W] : '0;
  assign out_im   = out_valid ? rd_data[W-1:0]   : '0;
  assign out_idx  = out_valid ? rd_cnt           : '0;
  assign out_last = out_valid && (rd_cnt == '1);

  // Writer and reader always own different banks, so both flag updates can land together.
  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == '1) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= ~wr_sel;
        end
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_cnt == '1) begin
          full[rd_sel] <= 1'b0;
          rd_sel       <= ~rd_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_bitrev_reorder.sv
// Directed bench for bitrev_reorder with a frame-level scoreboard model.
import fft_pkg::*;

module tb_bitrev_reorder;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_re;
  logic signed [15:0] in_im;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_re;
  logic signed [15:0] out_im;
  logic [2:0]         out_idx;
  logic               out_last;

  typedef struct {
    int                 idx;
    logic signed [15:0] re;
    logic signed [15:0] im;
  } exp_t;

  exp_t               expq[$];
  cplx_t              fr[$];
  logic signed [15:0] log_re[$];
  int                 n_chk;
  int                 n_fail;
  int                 acc;
  int                 acc0;

  bitrev_reorder #(.N(3), .W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rev3(input int i);
    logic [2:0] b;
    b = 3'(i);
    return int'({b[0], b[1], b[2]});
  endfunction

  // Checks outputs mid-cycle against the model, then advances one clock.
  task automatic cycle();
    exp_t e;
    int   pend;
    @(negedge clk);
    if (!rst) begin
      pend = (expq.size() + 7) / 8;
      check("out_valid", int'(out_valid), int'(expq.size() > 0));
      check("in_ready", int'(in_ready), int'(pend < 2));
      if (out_valid) begin
        if (expq.size() > 0) begin
          e = expq[0];
          check("out_idx", int'(out_idx), e.idx);
          check("out_re", int'(out_re), int'(e.re));
          check("out_im", int'(out_im), int'(e.im));
          check("out_last", int'(out_last), int'(e.idx == 7));
          if (out_ready) begin
            void'(expq.pop_front());
            log_re.push_back(out_re);
          end
        end
      end else begin
        check("idle_re_im", int'({out_re, out_im}), 0);
        check("idle_idx_last", int'({out_idx, out_last}), 0);
      end
      if (in_valid && in_ready) begin
        fr.push_back('{re: in_re, im: in_im});
        acc++;
        if (fr.size() == 8) begin
          for (int i = 0; i < 8; i++) begin
            expq.push_back('{idx: i, re: fr[rev3(i)].re, im: fr[rev3(i)].im});
          end
          fr.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      fr.delete();
      expq.delete();
      acc = 0;
    end
    in_re = 16'(acc);
    in_im = 16'(-acc);
  endtask

  initial begin
    int tbl[8];
    tbl = '{0, 4, 2, 6, 1, 5, 3, 7};
    n_chk = 0; n_fail = 0; acc = 0; acc0 = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_re = '0; in_im = '0;
    repeat (2) cycle();
    rst = 1'b0;
    repeat (2) cycle();

    // Single frame, k / -k
    log_re.delete();
    out_ready = 1'b1; in_valid = 1'b1;
    repeat (8) cycle();
    in_valid = 1'b0;
    repeat (10) cycle();
    check("t1_count", log_re.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < log_re.size()) check("t1_order", int'(log_re[i]), tbl[i]);
    end

    // Four back-to-back frames
    in_valid = 1'b1;
    repeat (32) cycle();
    in_valid = 1'b0;
    repeat (12) cycle();

    // Backpressure: two frames fill both banks, the 17th sample waits
    acc0 = acc;
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (17) cycle();
    check("bp_accepted", acc - acc0, 16);
    out_ready = 1'b1;
    for (int c = 0; c < 60 && (acc - acc0) < 24; c++) cycle();
    in_valid = 1'b0;
    check("bp_refill", acc - acc0, 24);
    repeat (30) cycle();

    // Output stall mid-frame
    in_valid = 1'b1;
    repeat (8) cycle();
    in_valid = 1'b0;
    for (int r = 0; r < 4; r++) begin
      out_ready = 1'b1; cycle();
      out_ready = 1'b0; cycle();
      out_ready = 1'b0; cycle();
      out_ready = 1'b1; cycle();
    end
    repeat (10) cycle();

    // Reset with frame 1 draining at idx 3 and 5 samples of frame 2 written
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (10) cycle();
    out_ready = 1'b1;
    repeat (3) cycle();
    check("pre_rst_idx", int'(out_idx), 3);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    out_ready = 1'b1; in_valid = 1'b1;
    repeat (8) cycle();
    in_valid = 1'b0;
    repeat (10) cycle();

    // Random input gaps over five frames
    acc0 = acc;
    for (int c = 0; c < 300 && (acc - acc0) < 40; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0;
    check("gap_accepted", acc - acc0, 40);
    repeat (20) cycle();

    check("drain_empty", expq.size(), 0);
    check("no_partial", fr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
